seq_110110_gen: RTL and testbench

SEQ_110110_GEN -- requirements
Module: seq_110110_gen

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_110110_gen_if.sv | 28 ++
 rtl/seq_piso.sv | 28 ++
 rtl/seq_110110_gen.sv | 138 +++++++++++++
 tb/tb_seq_110110_gen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared constants and FSM state type for the 110110 pattern generator and detector.
package seq_pkg;

    localparam int unsigned PAT_LEN = 6;
    localparam logic [PAT_LEN-1:0] DEFAULT_PAT = 6'b110110;
    localparam int unsigned FRAME_W = 4;
    localparam int unsigned GAP_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap,
        StDone
    } seq_state_e;

    // A frame count of zero still sends one frame.
    function automatic logic [FRAME_W-1:0] frames_eff(input logic [FRAME_W-1:0] cnt);
        return (cnt == '0) ? FRAME_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/seq_110110_gen_if.sv
// Control and serial-output bundle of the pattern generator.
interface seq_110110_gen_if #(
    parameter int unsigned PAT_LEN = 6
);
    import seq_pkg::*;

    logic               start;
    logic               abort;
    logic               use_default;
    logic [PAT_LEN-1:0] pattern;
    logic [FRAME_W-1:0] repeat_cnt;
    logic [GAP_W-1:0]   gap;
    logic               out;
    logic               valid;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, use_default, pattern, repeat_cnt, gap,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, abort, use_default, pattern, repeat_cnt, gap,
        output out, valid, busy, done
    );

endinterface

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register; MSB is the serial output, zeros shift in.
module seq_piso #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sr;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/seq_110110_gen.sv
// Framed serial pattern generator: repeats a latched pattern with optional idle gaps.
module seq_110110_gen #(
    parameter int unsigned        PAT_LEN     = seq_pkg::PAT_LEN,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = seq_pkg::DEFAULT_PAT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    seq_110110_gen_if.slave       bus
);
    import seq_pkg::*;

    localparam int unsigned     CNT_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_LEN - 1);

    seq_state_e         r_state;
    logic [PAT_LEN-1:0] r_pat;
    logic [FRAME_W-1:0] r_frames;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_start;
    logic               w_last_bit;
    logic               w_more;
    logic               w_reload;
    logic               w_load;
    logic               w_shift;
    logic               w_clear;
    logic [PAT_LEN-1:0] w_sel_pat;
    logic [PAT_LEN-1:0] w_load_data;
    logic               w_msb;

    assign w_sel_pat   = bus.use_default ? DEFAULT_PAT : bus.pattern;
    assign w_start     = (r_state == StIdle) && bus.start && !bus.abort;
    assign w_last_bit  = (r_state == StShift) && (r_bit_cnt == LAST_BIT);
    assign w_more      = r_frames > FRAME_W'(1);
    // Next frame's MSB must be on out in the cycle after the last bit or the last gap cycle.
    assign w_reload    = (w_last_bit && w_more && (r_gap == '0))
                       || ((r_state == StGap) && (r_gap_cnt == GAP_W'(1)));
    assign w_clear     = bus.abort;
    assign w_load      = w_start || w_reload;
    assign w_load_data = w_start ? w_sel_pat : r_pat;
    assign w_shift     = (r_state == StShift);

    seq_piso #(
        .WIDTH (PAT_LEN)
    ) u_piso (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_msb   (w_msb)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_pat     <= '0;
            r_frames  <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_bit_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_pat     <= w_sel_pat;
                        r_frames  <= frames_eff(bus.repeat_cnt);
                        r_gap     <= bus.gap;
                        r_bit_cnt <= '0;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    if (bus.abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (w_last_bit) begin
                        if (w_more) begin
                            r_frames  <= r_frames - FRAME_W'(1);
                            r_bit_cnt <= '0;
                            if (r_gap != '0) begin
                                r_gap_cnt <= r_gap;
                                r_valid   <= 1'b0;
                                r_state   <= StGap;
                            end
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                StGap: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_bit_cnt <= '0;
                        r_valid   <= 1'b1;
                        r_state   <= StShift;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.out   = w_msb;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_seq_110110_gen.sv
// Directed vector bench for seq_110110_gen with a behavioural 110110 loopback detector.
module tb_seq_110110_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_110110_gen_if #(.PAT_LEN(6)) bus ();

    seq_110110_gen #(
        .PAT_LEN     (6),
        .DEFAULT_PAT (6'b110110)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Loopback detector: shifts in out on valid cycles, registered hit one cycle later.
    logic [5:0] det_hist;
    logic       det_hit;
    always @(posedge clk) begin
        if (reset) begin
            det_hist <= '0;
            det_hit  <= 1'b0;
        end else begin
            if (bus.valid) det_hist <= {det_hist[4:0], bus.out};
            det_hit <= bus.valid && ({det_hist[4:0], bus.out} == 6'b110110);
        end
    end

    typedef struct {
        string      name;
        logic       start;
        logic       abort;
        logic       use_def;
        logic [5:0] pat;
        logic [3:0] rep;
        logic [2:0] gap;
        logic [4:0] exp;  // {out, valid, busy, done, det_hit}
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mkv(string n, logic s, logic a, logic ud, logic [5:0] p,
                                 logic [3:0] r, logic [2:0] g, logic [4:0] e);
        vec_t v;
        v.name = n; v.start = s; v.abort = a; v.use_def = ud;
        v.pat = p; v.rep = r; v.gap = g; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic ud, input logic [5:0] p,
                         input logic [3:0] r, input logic [2:0] g);
        bus.start = s; bus.abort = a; bus.use_default = ud;
        bus.pattern = p; bus.repeat_cnt = r; bus.gap = g;
    endtask

    // Observe n consecutive post-edge samples, starting with the current one.
    task automatic collect(input int n, output logic [63:0] s, output int nbits,
                           output int nbusy, output int ndone, output int ngap,
                           output int gap_out_bad, output int done_at, output int max_run);
        int run;
        s = '0; nbits = 0; nbusy = 0; ndone = 0; ngap = 0;
        gap_out_bad = 0; done_at = -1; max_run = 0; run = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.valid) begin
                s = {s[62:0], bus.out};
                nbits++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.busy) nbusy++;
            if (bus.busy && !bus.valid) begin
                ngap++;
                if (bus.out) gap_out_bad++;
            end
            if (bus.done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
    endtask

    initial begin
        logic [63:0] s;
        int nbits, nbusy, ndone, ngap, gob, done_at, max_run;
        logic found;

        vecs[0]  = mkv("def_b0",     1, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[1]  = mkv("def_b1",     0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[2]  = mkv("def_b2",     0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b01100);
        vecs[3]  = mkv("def_b3",     0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[4]  = mkv("def_b4",     0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[5]  = mkv("def_b5",     0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b01100);
        vecs[6]  = mkv("def_done",   0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b00011);
        vecs[7]  = mkv("def_idle",   0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b00000);
        vecs[8]  = mkv("r0_b0",      1, 0, 0, 6'b101001, 4'd0, 3'd0, 5'b11100);
        vecs[9]  = mkv("r0_restart", 1, 0, 0, 6'b101001, 4'd0, 3'd0, 5'b01100);
        vecs[10] = mkv("r0_chg_b2",  0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b11100);
        vecs[11] = mkv("r0_b3",      0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b01100);
        vecs[12] = mkv("r0_b4",      0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b01100);
        vecs[13] = mkv("r0_b5",      0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b11100);
        vecs[14] = mkv("r0_done",    0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b00010);
        vecs[15] = mkv("r0_idle",    0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b00000);
        vecs[16] = mkv("r0_no2nd",   0, 0, 1, 6'b111111, 4'd5, 3'd7, 5'b00000);
        vecs[17] = mkv("sa_both",    1, 1, 1, 6'h00, 4'd1, 3'd0, 5'b00000);
        vecs[18] = mkv("sa_after",   0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b00000);
        vecs[19] = mkv("ab_b0",      1, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[20] = mkv("ab_b1",      0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b11100);
        vecs[21] = mkv("ab_b2",      0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b01100);
        vecs[22] = mkv("ab_abort",   0, 1, 1, 6'h00, 4'd1, 3'd0, 5'b00000);
        vecs[23] = mkv("ab_idle",    0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b00000);
        vecs[24] = mkv("ab_idle2",   0, 0, 1, 6'h00, 4'd1, 3'd0, 5'b00000);

        // Reset, with start asserted to show reset wins.
        drive(1, 0, 1, 6'h00, 4'd1, 3'd0);
        reset = 1'b1;
        tick();
        tick();
        check("rst_outs", {bus.out, bus.valid, bus.busy, bus.done}, 4'b0000);
        reset = 1'b0;
        drive(0, 0, 1, 6'h00, 4'd1, 3'd0);
        tick();
        check("rst_idle", {bus.out, bus.valid, bus.busy, bus.done}, 4'b0000);

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].use_def, vecs[i].pat,
                  vecs[i].rep, vecs[i].gap);
            tick();
            check(vecs[i].name, {bus.out, bus.valid, bus.busy, bus.done, det_hit}, vecs[i].exp);
        end

        // Three framed repeats with two-cycle gaps.
        drive(1, 0, 0, 6'b101001, 4'd3, 3'd2);
        tick();
        drive(0, 0, 0, 6'b000000, 4'd0, 3'd0);
        collect(40, s, nbits, nbusy, ndone, ngap, gob, done_at, max_run);
        check("gap_busy_cycles", 64'(nbusy), 64'd22);
        check("gap_bits", 64'(nbits), 64'd18);
        check("gap_stream", s, 64'(18'b101001101001101001));
        check("gap_cycles", 64'(ngap), 64'd4);
        check("gap_out_zero", 64'(gob), 64'd0);
        check("gap_done_once", 64'(ndone), 64'd1);
        check("gap_done_at", 64'(done_at), 64'd22);

        // Two frames back-to-back.
        drive(1, 0, 1, 6'h00, 4'd2, 3'd0);
        tick();
        drive(0, 0, 1, 6'h00, 4'd2, 3'd0);
        collect(20, s, nbits, nbusy, ndone, ngap, gob, done_at, max_run);
        check("b2b_stream", s, 64'(12'b110110110110));
        check("b2b_run", 64'(max_run), 64'd12);
        check("b2b_busy", 64'(nbusy), 64'd12);
        check("b2b_done_at", 64'(done_at), 64'd12);

        // Reset landing on a gap cycle, then a clean frame.
        drive(1, 0, 0, 6'b101001, 4'd2, 3'd3);
        tick();
        drive(0, 0, 0, 6'b101001, 4'd2, 3'd3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.busy && !bus.valid) found = 1'b1;
            else tick();
        end
        check("rst_gap_reached", 64'(found), 64'd1);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        check("rst_gap_outs", {bus.out, bus.valid, bus.busy, bus.done}, 4'b0000);
        reset = 1'b0;
        bus.start = 1'b0;
        tick();
        check("rst_gap_quiet", {bus.out, bus.valid, bus.busy, bus.done}, 4'b0000);
        drive(1, 0, 1, 6'h00, 4'd1, 3'd0);
        tick();
        drive(0, 0, 1, 6'h00, 4'd1, 3'd0);
        collect(10, s, nbits, nbusy, ndone, ngap, gob, done_at, max_run);
        check("post_rst_stream", s, 64'(6'b110110));
        check("post_rst_bits", 64'(nbits), 64'd6);
        check("post_rst_done_at", 64'(done_at), 64'd6);
        check("post_rst_done_once", 64'(ndone), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
